dsp_lut_bank_ctrl: RTL and testbench

DSP_LUT_BANK_CTRL -- requirements
Module: dsp_lut_bank_ctrl

---
 rtl/dsp_lut_bank_ctrl.sv | 126 ++++++++++++
 tb/tb_dsp_lut_bank_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_lut_bank_ctrl.sv
// Double-buffered LUT bank controller: host writes and zero-fill go to the shadow bank, swap exchanges banks between samples.
// Optional swap watchdog with sticky swap_forced flag: define LUT_BANK_CTRL_WDOG_EN.
module dsp_lut_bank_ctrl #(
  parameter int IN_WIDTH    = 8,
  parameter int OUT_WIDTH   = 7,
  parameter int WDOG_CYCLES = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic                 wr_req,
  input  logic [IN_WIDTH-1:0]  wr_addr,
  input  logic [OUT_WIDTH-1:0] wr_data,
  output logic                 wr_ack,
  input  logic                 swap_req,
  input  logic                 clr_req,
  output logic                 lut_wr_en,
  output logic                 lut_wr_bank,
  output logic [IN_WIDTH-1:0]  lut_wr_addr,
  output logic [OUT_WIDTH-1:0] lut_wr_data,
  output logic                 active_bank,
  output logic                 busy,
  output logic                 swap_done,
  output logic                 clr_done
`ifdef LUT_BANK_CTRL_WDOG_EN
  ,
  output logic                 swap_forced
`endif
);

  typedef enum logic [1:0] {IDLE, CLEAR, SWAP_WAIT} state_t;

  localparam logic [IN_WIDTH-1:0] LAST_ADDR = '1;

  state_t              state;
  logic [IN_WIDTH-1:0] clr_cnt;
  logic                swap_go;

  // Host writes only slip in when no higher-priority request shares the cycle.
  assign wr_ack = wr_req && !rst && (state == IDLE) && !clr_req && !swap_req;
  assign busy   = (state != IDLE);

`ifdef LUT_BANK_CTRL_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

  logic [WDOG_W-1:0] wdog_cnt;
  logic              wdog_hit;

  assign wdog_hit = (wdog_cnt == WDOG_W'(WDOG_CYCLES));
  assign swap_go  = (!we || wdog_hit) && !lut_wr_en;
`else
  assign swap_go  = !we && !lut_wr_en;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      active_bank <= 1'b0;
      clr_cnt     <= '0;
      lut_wr_en   <= 1'b0;
      lut_wr_bank <= 1'b0;
      lut_wr_addr <= '0;
      lut_wr_data <= '0;
      swap_done   <= 1'b0;
      clr_done    <= 1'b0;
`ifdef LUT_BANK_CTRL_WDOG_EN
      wdog_cnt    <= '0;
      swap_forced <= 1'b0;
`endif
    end else begin
      lut_wr_en <= 1'b0;
      swap_done <= 1'b0;
      clr_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_req) begin
            state   <= CLEAR;
            clr_cnt <= '0;
          end else if (swap_req) begin
            state <= SWAP_WAIT;
`ifdef LUT_BANK_CTRL_WDOG_EN
            wdog_cnt <= '0;
`endif
          end else if (wr_req) begin
            lut_wr_en   <= 1'b1;
            lut_wr_bank <= ~active_bank;
            lut_wr_addr <= wr_addr;
            lut_wr_data <= wr_data;
          end
        end
        CLEAR: begin
          // clr_done flags the final write; the following cycle only leaves the state.
          if (clr_done) begin
            state <= IDLE;
          end else begin
            lut_wr_en   <= 1'b1;
            lut_wr_bank <= ~active_bank;
            lut_wr_addr <= clr_cnt;
            lut_wr_data <= '0;
            if (clr_cnt == LAST_ADDR) begin
              clr_done <= 1'b1;
            end else begin
              clr_cnt <= clr_cnt + 1'b1;
            end
          end
        end
        SWAP_WAIT: begin
          if (swap_go) begin
            active_bank <= ~active_bank;
            swap_done   <= 1'b1;
            state       <= IDLE;
`ifdef LUT_BANK_CTRL_WDOG_EN
            if (wdog_hit && we) begin
              swap_forced <= 1'b1;
            end
          end else if (we) begin
            wdog_cnt <= wdog_cnt + 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_lut_bank_ctrl.sv
// Bench for dsp_lut_bank_ctrl: directed scenarios plus random traffic against a transaction-level model.
module tb_dsp_lut_bank_ctrl;

  localparam int IN_W  = 8;
  localparam int OUT_W = 7;
  localparam int WDOG  = 256;
  localparam int N     = 1 << IN_W;

  logic             clk = 1'b0;
  logic             rst, we, wr_req, swap_req, clr_req;
  logic [IN_W-1:0]  wr_addr;
  logic [OUT_W-1:0] wr_data;
  logic             wr_ack, lut_wr_en, lut_wr_bank, active_bank, busy, swap_done, clr_done;
  logic [IN_W-1:0]  lut_wr_addr;
  logic [OUT_W-1:0] lut_wr_data;
`ifdef LUT_BANK_CTRL_WDOG_EN
  logic             swap_forced;
`endif

  dsp_lut_bank_ctrl #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .WDOG_CYCLES(WDOG)) dut (
    .clk(clk), .rst(rst), .we(we), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .swap_req(swap_req), .clr_req(clr_req), .lut_wr_en(lut_wr_en),
    .lut_wr_bank(lut_wr_bank), .lut_wr_addr(lut_wr_addr), .lut_wr_data(lut_wr_data),
    .active_bank(active_bank), .busy(busy), .swap_done(swap_done), .clr_done(clr_done)
`ifdef LUT_BANK_CTRL_WDOG_EN
    , .swap_forced(swap_forced)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: mode 0 = idle, 1 = clearing, 2 = waiting to swap.
  int               m_mode = 0;
  bit               m_bank = 0;
  int               m_issued = 0;
  int               m_wd = 0;
  bit               m_forced = 0;
  bit               e_wen = 0, e_bank = 0, e_sd = 0, e_cd = 0, e_rst = 0;
  logic [IN_W-1:0]  e_addr = '0;
  logic [OUT_W-1:0] e_data = '0;
  logic             ack_seen = 1'b0;

  task automatic model_step();
    bit nw, nsd, ncd, forced;
    nw = 0; nsd = 0; ncd = 0; forced = 0;
    e_rst = rst;
    if (rst) begin
      m_mode = 0; m_bank = 0; m_forced = 0;
      e_addr = '0; e_data = '0; e_bank = 0;
    end else begin
      case (m_mode)
        0: begin
          if (clr_req) begin
            m_mode = 1; m_issued = 0;
          end else if (swap_req) begin
            m_mode = 2; m_wd = 0;
          end else if (wr_req) begin
            nw = 1; e_addr = wr_addr; e_data = wr_data; e_bank = !m_bank;
          end
        end
        1: begin
          if (m_issued == N) begin
            m_mode = 0;
          end else begin
            nw = 1; e_addr = m_issued[IN_W-1:0]; e_data = '0; e_bank = !m_bank;
            ncd = (m_issued == N - 1);
            m_issued++;
          end
        end
        default: begin
`ifdef LUT_BANK_CTRL_WDOG_EN
          forced = (m_wd >= WDOG);
`endif
          if ((!we || forced) && !e_wen) begin
            m_bank = !m_bank; nsd = 1; m_mode = 0;
            if (forced && we) m_forced = 1;
          end else begin
            m_wd++;
          end
        end
      endcase
    end
    e_wen = nw; e_sd = nsd; e_cd = ncd;
  endtask

  task automatic cycle();
    #1;
    ack_seen = wr_ack;
    chk("wr_ack", wr_ack, !rst && m_mode == 0 && wr_req && !clr_req && !swap_req);
    model_step();
    @(posedge clk);
    #1;
    chk("lut_wr_en", lut_wr_en, e_wen);
    chk("active_bank", active_bank, m_bank);
    chk("busy", busy, m_mode != 0);
    chk("swap_done", swap_done, e_sd);
    chk("clr_done", clr_done, e_cd);
    if (e_wen || e_rst) begin
      chk("lut_wr_addr", lut_wr_addr, e_addr);
      chk("lut_wr_data", lut_wr_data, e_data);
      chk("lut_wr_bank", lut_wr_bank, e_bank);
    end
`ifdef LUT_BANK_CTRL_WDOG_EN
    chk("swap_forced", swap_forced, m_forced);
`endif
  endtask

  int  cnt, sd, done_addr;
  bit  found;
  bit  pat [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    rst = 1; we = 0; wr_req = 0; swap_req = 0; clr_req = 0; wr_addr = '0; wr_data = '0;
    repeat (2) cycle();
    rst = 0;
    chk("rst_en", lut_wr_en, 0);
    chk("rst_bank", active_bank, 0);
    chk("rst_busy", busy, 0);

    // Single host write lands in shadow bank 1 one cycle after ack.
    wr_req = 1; wr_addr = 8'h05; wr_data = 7'h3F;
    #1 chk("w_ack_now", wr_ack, 1);
    cycle();
    wr_req = 0;
    chk("w_en", lut_wr_en, 1);
    chk("w_addr", lut_wr_addr, 8'h05);
    chk("w_data", lut_wr_data, 7'h3F);
    chk("w_bank", lut_wr_bank, 1);
    cycle();

    // Full clear.
    clr_req = 1; cycle(); clr_req = 0;
    cnt = 0; done_addr = -1;
    for (int i = 0; i < N + 2; i++) begin
      cycle();
      if (lut_wr_en) begin
        chk("clr_seq_addr", lut_wr_addr, cnt);
        cnt++;
      end
      if (clr_done) done_addr = lut_wr_addr;
    end
    chk("clr_count", cnt, N);
    chk("clr_done_addr", done_addr, N - 1);
    chk("clr_busy_after", busy, 0);

    // Swap requested while we=1, completes on first we=0 cycle.
    sd = 0; we = 1; swap_req = 1; cycle(); swap_req = 0;
    for (int i = 0; i < 4; i++) begin
      we = pat[i]; cycle(); sd += swap_done;
    end
    we = 0;
    chk("swap_pulses", sd, 1);
    chk("swap_bank", active_bank, 1);
    wr_req = 1; wr_addr = 8'h11; wr_data = 7'h22; cycle(); wr_req = 0;
    chk("post_swap_wbank", lut_wr_bank, 0);

    // All three requests at once: clear wins.
    clr_req = 1; swap_req = 1; wr_req = 1;
    #1 chk("prio_ack", wr_ack, 0);
    cycle();
    clr_req = 0; swap_req = 0; wr_req = 0;
    sd = 0;
    for (int i = 0; i < N + 2; i++) begin cycle(); sd += swap_done; end
    chk("prio_no_swap", sd, 0);
    chk("prio_bank", active_bank, 1);
    chk("prio_busy", busy, 0);

    // Reset in the middle of a clear.
    clr_req = 1; cycle(); clr_req = 0;
    found = 0;
    for (int i = 0; i < N + 8; i++) begin
      if (lut_wr_en && lut_wr_addr == 8'd100) begin found = 1; break; end
      cycle();
    end
    chk("reach_addr100", found, 1);
    rst = 1; cycle(); rst = 0;
    chk("abort_en", lut_wr_en, 0);
    chk("abort_done", clr_done, 0);
    chk("abort_bank", active_bank, 0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin cycle(); cnt += clr_done; end
    chk("abort_no_done", cnt, 0);

    // we held high during swap wait.
    we = 1; swap_req = 1; cycle(); swap_req = 0;
    sd = 0;
    for (int i = 0; i < WDOG + 4; i++) begin cycle(); sd += swap_done; end
`ifdef LUT_BANK_CTRL_WDOG_EN
    chk("wdog_swaps", sd, 1);
    chk("wdog_forced", swap_forced, 1);
    chk("wdog_bank", active_bank, 1);
`else
    chk("nowdog_swaps", sd, 0);
    chk("nowdog_busy", busy, 1);
    chk("nowdog_bank", active_bank, 0);
    we = 0; cycle();
`endif

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 399) == 0);
      we       = 1'($urandom_range(0, 1));
      clr_req  = ($urandom_range(0, 149) == 0);
      swap_req = ($urandom_range(0, 19) == 0);
      if (!(wr_req && !ack_seen)) begin
        wr_req  = ($urandom_range(0, 2) != 0);
        wr_addr = 8'($urandom_range(0, 255));
        wr_data = 7'($urandom_range(0, 127));
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
